// File: rtl/dig_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan scheduler: bus address,
// register reset values, FSM state encoding and a one-hot helper.
package dig_scan_ctrl_pkg;

    localparam logic [31:0] PERI_ADDR_DIG_CTRL = 32'h0000_0040;
    localparam logic [7:0]  DSC_MASK_RST       = 8'hFF;
    localparam logic        DSC_RUN_RST        = 1'b1;

    typedef enum logic [1:0] {
        DSC_IDLE  = 2'd0,
        DSC_SHOW  = 2'd1,
        DSC_BLANK = 2'd2
    } dsc_state_e;

    function automatic logic [7:0] onehot8(input logic [2:0] i);
        return 8'b0000_0001 << i;
    endfunction

endpackage

// File: rtl/dig_scan_ctrl.sv
// Digit scan scheduler: control register (mask, run), SHOW/BLANK slot FSM,
// slot counter and digit index counter for an 8-digit seven-segment display.
module dig_scan_ctrl
    import dig_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIG   = 8,
    parameter int SHOW_CYC  = 50000,
    parameter int BLANK_CYC = 500,
    parameter int CNT_W     = 32
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] rdata_o,
    output logic [2:0]  nibble_sel_o,
    output logic [7:0]  dig_en_o,
    output logic        blank_o,
    output logic        frame_done_o
);

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYC > 0) ? CNT_W'(BLANK_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [2:0]       IDX_LAST   = 3'(NUM_DIG - 1);
    localparam bit               NO_BLANK   = (BLANK_CYC == 0);

    dsc_state_e       state_q, state_d;
    logic [2:0]       idx_q, idx_d, idx_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       mask_q, mask_d;
    logic             run_q, run_d;
    logic             wr_hit;
    logic             advance;
    logic             unused_data;

    // Bus writes are single-cycle strobes with no ready: a matching write is
    // always accepted on the edge that samples we_i high.
    assign wr_hit      = we_i && (addr_i == PERI_ADDR_DIG_CTRL);
    assign mask_d      = wr_hit ? data_i[7:0] : mask_q;
    assign run_d       = wr_hit ? data_i[8]   : run_q;
    assign unused_data = ^data_i[31:9];

    assign idx_nxt = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
    assign advance = ((state_q == DSC_SHOW)  && (cnt_q == SHOW_LAST) && NO_BLANK) ||
                     ((state_q == DSC_BLANK) && (cnt_q == BLANK_LAST));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= DSC_IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
            mask_q  <= DSC_MASK_RST;
            run_q   <= DSC_RUN_RST;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            run_q   <= run_d;
        end
    end

    // The incoming run value steers the FSM so a stop lands on the same edge
    // as the write, overriding any slot boundary.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (!run_d) begin
            state_d = DSC_IDLE;
            idx_d   = 3'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                DSC_IDLE: begin
                    state_d = DSC_SHOW;
                    idx_d   = 3'd0;
                    cnt_d   = '0;
                end
                DSC_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        cnt_d = '0;
                        if (NO_BLANK) begin
                            idx_d = idx_nxt;
                        end else begin
                            state_d = DSC_BLANK;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                DSC_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = DSC_SHOW;
                        cnt_d   = '0;
                        idx_d   = idx_nxt;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = DSC_IDLE;
                    idx_d   = 3'd0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign dig_en_o     = (state_q == DSC_SHOW) ? (onehot8(idx_q) & mask_q) : 8'h00;
    assign blank_o      = (state_q != DSC_SHOW);
    assign frame_done_o = advance && (idx_q == IDX_LAST) && run_d;
    assign nibble_sel_o = idx_q;
    assign rdata_o      = {13'b0, idx_q, 7'b0, run_q, mask_q};

endmodule

// File: tb/tb_dig_scan_ctrl.sv
// Directed bench for dig_scan_ctrl: expectations are queued per cycle by the
// stimulus thread and checked by an independent negedge monitor.
module tb_dig_scan_ctrl;
    import dig_scan_ctrl_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] data_i = 32'h0;
    logic [31:0] rdata_o;
    logic [2:0]  nibble_sel_o;
    logic [7:0]  dig_en_o;
    logic        blank_o;
    logic        frame_done_o;
    logic [31:0] rdata0;
    logic [2:0]  nibble0;
    logic [7:0]  dig_en0;
    logic        blank0;
    logic        frame_done0;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    logic [71:0] exp_q[$];

    dig_scan_ctrl #(.NUM_DIG(8), .SHOW_CYC(4), .BLANK_CYC(2), .CNT_W(32)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .we_i(we_i), .addr_i(addr_i), .data_i(data_i),
        .rdata_o(rdata_o), .nibble_sel_o(nibble_sel_o), .dig_en_o(dig_en_o),
        .blank_o(blank_o), .frame_done_o(frame_done_o)
    );

    dig_scan_ctrl #(.NUM_DIG(8), .SHOW_CYC(4), .BLANK_CYC(0), .CNT_W(32)) dut0 (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .we_i(we_i), .addr_i(addr_i), .data_i(data_i),
        .rdata_o(rdata0), .nibble_sel_o(nibble0), .dig_en_o(dig_en0),
        .blank_o(blank0), .frame_done_o(frame_done0)
    );

    // clock / reset-relative cycle counter
    initial forever #5 clk_i = ~clk_i;

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // field selectors: 0 dig_en 1 blank 2 nibble 3 frame_done 4 rdata
    //                  5 dig_en(no-blank) 6 blank(no-blank) 7 frame_done(no-blank)
    function automatic logic [31:0] actual(input int sel);
        case (sel)
            0: return {24'h0, dig_en_o};
            1: return {31'h0, blank_o};
            2: return {29'h0, nibble_sel_o};
            3: return {31'h0, frame_done_o};
            4: return rdata_o;
            5: return {24'h0, dig_en0};
            6: return {31'h0, blank0};
            default: return {31'h0, frame_done0};
        endcase
    endfunction

    function automatic string fname(input int sel);
        case (sel)
            0: return "dig_en";
            1: return "blank";
            2: return "nibble_sel";
            3: return "frame_done";
            4: return "rdata";
            5: return "nb_dig_en";
            6: return "nb_blank";
            default: return "nb_frame_done";
        endcase
    endfunction

    // driver tasks
    task automatic expect_at(input int c, input int sel, input logic [31:0] v);
        logic [31:0] c32;
        logic [7:0]  s8;
        c32 = c;
        s8  = sel[7:0];
        exp_q.push_back({c32, s8, v});
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk_i);
            #2;
        end
    endtask

    task automatic bus_wr(input int c, input logic [31:0] a, input logic [31:0] d);
        wait_until(c);
        we_i = 1'b1; addr_i = a; data_i = d;
        @(posedge clk_i);
        #2;
        we_i = 1'b0; addr_i = 32'h0; data_i = 32'h0;
    endtask

    task automatic expect_reset_state();
        expect_at(0, 0, 32'h00); expect_at(0, 1, 32'h1); expect_at(0, 2, 32'h0);
        expect_at(0, 3, 32'h0);  expect_at(0, 4, 32'h0000_01FF);
        expect_at(0, 5, 32'h00); expect_at(0, 6, 32'h1);
    endtask

    // scoreboard monitor
    always @(negedge clk_i) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            logic [71:0] e;
            int          ec;
            int          es;
            logic [31:0] act;
            e  = exp_q[i];
            ec = int'(e[71:40]);
            es = int'(e[39:32]);
            if (ec == cyc) begin
                act = actual(es);
                n_cmp++;
                if (act !== e[31:0]) begin
                    n_bad++;
                    $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", fname(es), cyc, act, e[31:0]);
                end
                exp_q.delete(i);
            end else if (ec < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s cyc=%0d missed check for cyc %0d", fname(es), cyc, ec);
                exp_q.delete(i);
            end
        end
    end

    initial begin
        // reset state and first frames of both variants
        expect_reset_state();
        expect_at(1, 0, 32'h01); expect_at(1, 1, 32'h0); expect_at(1, 2, 32'h0);
        expect_at(1, 5, 32'h01); expect_at(1, 6, 32'h0);
        expect_at(4, 0, 32'h01);
        expect_at(5, 0, 32'h00); expect_at(5, 1, 32'h1); expect_at(5, 5, 32'h02); expect_at(5, 6, 32'h0);
        expect_at(6, 1, 32'h1);  expect_at(6, 6, 32'h0);
        expect_at(7, 0, 32'h02); expect_at(7, 2, 32'h1);
        expect_at(29, 5, 32'h80);
        expect_at(31, 7, 32'h0); expect_at(32, 7, 32'h1);
        expect_at(33, 5, 32'h01); expect_at(33, 7, 32'h0); expect_at(64, 7, 32'h1);
        expect_at(43, 0, 32'h80); expect_at(43, 2, 32'h7);
        expect_at(47, 1, 32'h1);  expect_at(47, 3, 32'h0);
        expect_at(48, 3, 32'h1);  expect_at(48, 2, 32'h7);
        expect_at(49, 0, 32'h01); expect_at(49, 2, 32'h0); expect_at(49, 3, 32'h0);
        expect_at(95, 3, 32'h0);  expect_at(96, 3, 32'h1); expect_at(144, 3, 32'h1);
        #12 rst_n_i = 1'b1;

        // mask 0x0F with run
        expect_at(151, 0, 32'h02); expect_at(151, 4, 32'h0001_010F);
        expect_at(163, 0, 32'h08); expect_at(163, 2, 32'h3);
        expect_at(169, 0, 32'h00); expect_at(169, 2, 32'h4); expect_at(169, 1, 32'h0);
        expect_at(187, 0, 32'h00);
        expect_at(191, 3, 32'h0);  expect_at(192, 3, 32'h1);
        bus_wr(150, PERI_ADDR_DIG_CTRL, 32'h0000_010F);

        // write to a neighbouring address is ignored
        expect_at(201, 0, 32'h02); expect_at(201, 2, 32'h1); expect_at(201, 4, 32'h0001_010F);
        expect_at(240, 3, 32'h1);
        bus_wr(200, PERI_ADDR_DIG_CTRL + 32'd4, 32'h0);

        // stop during SHOW of idx 3, then restart
        expect_at(260, 0, 32'h08);
        expect_at(261, 0, 32'h00); expect_at(261, 1, 32'h1); expect_at(261, 2, 32'h0);
        expect_at(261, 4, 32'h0000_00FF);
        expect_at(263, 0, 32'h00); expect_at(263, 1, 32'h1);
        bus_wr(260, PERI_ADDR_DIG_CTRL, 32'h0000_00FF);
        expect_at(266, 0, 32'h01); expect_at(266, 1, 32'h0); expect_at(266, 2, 32'h0);
        expect_at(266, 4, 32'h0000_01FF);
        expect_at(272, 0, 32'h02);
        expect_at(312, 3, 32'h0);  expect_at(313, 3, 32'h1);
        bus_wr(265, PERI_ADDR_DIG_CTRL, 32'h0000_01FF);

        // run rewritten while running: new mask, no restart
        expect_at(321, 0, 32'h00); expect_at(321, 2, 32'h1); expect_at(321, 4, 32'h0001_013C);
        expect_at(326, 0, 32'h04);
        expect_at(395, 0, 32'h20); expect_at(395, 2, 32'h5);
        bus_wr(320, PERI_ADDR_DIG_CTRL, 32'h0000_013C);

        // asynchronous reset mid-BLANK of idx 5
        wait_until(396);
        rst_n_i = 1'b0;
        expect_reset_state();
        expect_at(1, 0, 32'h01); expect_at(1, 2, 32'h0); expect_at(1, 4, 32'h0000_01FF);
        expect_at(1, 5, 32'h01);
        expect_at(5, 0, 32'h00); expect_at(5, 1, 32'h1);
        @(negedge clk_i);
        @(posedge clk_i);
        #2 rst_n_i = 1'b1;
        wait_until(12);

        foreach (exp_q[i]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s never checked (cyc %0d)", fname(int'(exp_q[i][39:32])), int'(exp_q[i][71:40]));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
